store_buffer: RTL

- Write-buffer stage between the pipeline core's data-memory port (MemWrite/DataAdr/WriteData/ReadData) and the single-port dmem.
- Accepts word stores into a FIFO and drains them to dmem in program order whenever the port is not needed by a load.
- Forwards buffered store data to younger loads to the same word.
- Asserts a stall to the core when a store arrives and the FIFO is full.

---
 rtl/store_buffer_if.sv | 30 +++
 rtl/store_buffer.sv | 96 +++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// Bus bundle between the core's data-memory port, the store buffer and dmem.
// The master side is the core plus dmem. The slave side is the store buffer.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
);
  logic                       cpu_we;
  logic                       cpu_re;
  logic [AW-1:0]              cpu_adr;
  logic [DW-1:0]              cpu_wdata;
  logic [DW-1:0]              cpu_rdata;
  logic                       stall;
  logic                       mem_we;
  logic [AW-1:0]              mem_adr;
  logic [DW-1:0]              mem_wdata;
  logic [DW-1:0]              mem_rdata;
  logic [$clog2(DEPTH):0]     count;
  logic                       empty;

  modport master (
    output cpu_we, cpu_re, cpu_adr, cpu_wdata, mem_rdata,
    input  cpu_rdata, stall, mem_we, mem_adr, mem_wdata, count, empty
  );

  modport slave (
    input  cpu_we, cpu_re, cpu_adr, cpu_wdata, mem_rdata,
    output cpu_rdata, stall, mem_we, mem_adr, mem_wdata, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between the core data port and a single-port dmem.
// Stores are queued in a FIFO and drained in order whenever no load needs the port.
// Loads forward data from the youngest buffered store to the same word.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;

  logic [AW-3:0] adr_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  ptr_t          head_q, head_d;
  ptr_t          tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          is_empty;
  logic          push;
  logic          pop;
  logic          hit;
  logic [DW-1:0] fwd_data;
  ptr_t          idx;

  assign is_empty = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  // Loads own the port, so a drain only happens on cycles with no load.
  assign push     = bus.cpu_we & ~full;
  assign pop      = ~bus.cpu_re & ~is_empty;

  // Next-state logic for the pointers and the occupancy count.
  always_comb begin
    head_d  = pop  ? ptr_t'(head_q + 1'b1) : head_q;
    tail_d  = push ? ptr_t'(tail_q + 1'b1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers. Reset empties the queue at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage. Validity comes from count, so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_q[tail_q]  <= bus.cpu_adr[AW-1:2];
      data_q[tail_q] <= bus.cpu_wdata;
    end
  end

  // Forwarding search runs from oldest to youngest. The last hit wins, so the youngest match is returned.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + ptr_t'(k);
      if ((CW'(k) < count_q) && (adr_q[idx] == bus.cpu_adr[AW-1:2])) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // Port arbitration and core-facing outputs.
  always_comb begin
    bus.mem_we    = pop;
    bus.mem_adr   = (bus.cpu_re || is_empty) ? bus.cpu_adr : {adr_q[head_q], 2'b00};
    bus.mem_wdata = data_q[head_q];
    bus.cpu_rdata = (bus.cpu_re && hit) ? fwd_data : bus.mem_rdata;
    bus.stall     = bus.cpu_we & full;
    bus.count     = count_q;
    bus.empty     = is_empty;
  end
endmodule
